alu_op_dispatch: RTL and testbench

Request front-end of the 8-bit ALU: accepts one operation (op code plus two operands) over a valid/ready handshake and drives the 3-bit result-select bus into the 8:1 result multiplexer. It also drives one-hot unit enables and start pulses for the multi-cycle multiply and divide units, then captures the selected result and returns it with flags over a second valid/ready handshake. It sits between the operand/control source and the functional units plus result mux.

---
 rtl/alu_op_dispatch.sv | 162 ++++++++++++++++
 tb/tb_alu_op_dispatch.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_dispatch.sv
// Request front-end of the 8-bit ALU: accepts an op over valid/ready, drives unit enables/starts
// and the result-mux select, and returns the captured result with flags. Optional: ALU_DISPATCH_TIMEOUT_EN.
module alu_op_dispatch #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [2:0] req_op,
  input  logic [7:0] req_a,
  input  logic [7:0] req_b,
  output logic [7:0] op_a,
  output logic [7:0] op_b,
  output logic [2:0] unit_sel,
  output logic [7:0] unit_en,
  output logic       unit_start,
  input  logic [7:0] unit_result,
  input  logic       mul_done,
  input  logic       div_done,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_data,
  output logic       res_zero,
  output logic       res_err,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_DIV = 3'b110;
  localparam logic [7:0] ERR_RESULT = 8'hFF;

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("alu_op_dispatch: TIMEOUT must be in 1..255");
  end

  state_t     state_q;
  state_t     state_d;
  logic       accept;
  logic       cap_en;
  logic [7:0] cap_data;
  logic       cap_err;
  logic       unit_done;
  logic       timeout_hit;

  assign accept    = req_valid && req_ready;
  assign unit_done = (unit_sel == OP_MUL) ? mul_done : div_done;

`ifdef ALU_DISPATCH_TIMEOUT_EN
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  logic [7:0] wait_cnt;

  // Counts completed WAIT cycles; fires on the TIMEOUT-th cycle without a done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (state_q == S_ISSUE) begin
      wait_cnt <= '0;
    end else if (state_q == S_WAIT) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  assign timeout_hit = (state_q == S_WAIT) && (wait_cnt == WAIT_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    cap_en     = 1'b0;
    cap_data   = unit_result;
    cap_err    = 1'b0;
    unit_start = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (unit_sel == OP_DIV && op_b == 8'h00) begin
          cap_en   = 1'b1;
          cap_data = ERR_RESULT;
          cap_err  = 1'b1;
          state_d  = S_DONE;
        end else if (unit_sel == OP_MUL || unit_sel == OP_DIV) begin
          unit_start = 1'b1;
          state_d    = S_WAIT;
        end else begin
          cap_en  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_WAIT: begin
        // A done arriving on the timeout cycle still delivers the real result.
        if (unit_done) begin
          cap_en  = 1'b1;
          state_d = S_DONE;
        end else if (timeout_hit) begin
          cap_en   = 1'b1;
          cap_data = ERR_RESULT;
          cap_err  = 1'b1;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        if (res_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      unit_sel <= '0;
      op_a     <= '0;
      op_b     <= '0;
      res_data <= '0;
      res_zero <= 1'b0;
      res_err  <= 1'b0;
    end else begin
      if (accept) begin
        unit_sel <= req_op;
        op_a     <= req_a;
        op_b     <= req_b;
      end
      if (cap_en) begin
        res_data <= cap_data;
        res_zero <= (cap_data == 8'h00);
        res_err  <= cap_err;
      end
    end
  end

  // req_ready is gated by rst directly so it is low for the whole reset pulse.
  assign req_ready = (state_q == S_IDLE) && !rst;
  assign unit_en   = (state_q == S_ISSUE || state_q == S_WAIT) ? (8'b1 << unit_sel) : 8'h00;
  assign res_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_op_dispatch.sv
// Self-checking bench for alu_op_dispatch: table of directed ops plus hand sequences for
// result hold, multiply/divide waits, timeout (ALU_DISPATCH_TIMEOUT_EN) and mid-operation reset.
module tb_alu_op_dispatch;

  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [2:0] req_op = '0;
  logic [7:0] req_a = '0;
  logic [7:0] req_b = '0;
  logic [7:0] op_a, op_b;
  logic [2:0] unit_sel;
  logic [7:0] unit_en;
  logic       unit_start;
  logic [7:0] unit_result;
  logic       mul_done, div_done;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [7:0] res_data;
  logic       res_zero, res_err, busy;

  logic resp_mul = 1'b0, resp_div = 1'b0;
  logic man_mul = 1'b0, man_div = 1'b0;
  bit   auto_done = 1'b0;

  int tests = 0;
  int fails = 0;

  assign mul_done = resp_mul | man_mul;
  assign div_done = resp_div | man_div;

  alu_op_dispatch #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .op_a(op_a), .op_b(op_b), .unit_sel(unit_sel), .unit_en(unit_en),
    .unit_start(unit_start), .unit_result(unit_result),
    .mul_done(mul_done), .div_done(div_done),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_zero(res_zero), .res_err(res_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Result-mux model: the functional units computed from the latched operands.
  always_comb begin
    unit_result = 8'h00;
    case (unit_sel)
      3'd0: unit_result = op_a + op_b;
      3'd1: unit_result = op_a - op_b;
      3'd2: unit_result = op_a | op_b;
      3'd3: unit_result = op_a & op_b;
      3'd4: unit_result = op_a ^ op_b;
      3'd5: unit_result = op_a * op_b;
      3'd6: unit_result = (op_b == 8'h00) ? 8'h00 : op_a / op_b;
      default: unit_result = ~op_a;
    endcase
  end

  // Auto responder: strobes the matching done three cycles after a start pulse.
  initial begin
    forever begin
      @(negedge clk);
      if (auto_done && unit_start) begin
        logic is_mul;
        is_mul = (unit_sel == 3'b101);
        repeat (3) @(negedge clk);
        resp_mul = is_mul;
        resp_div = !is_mul;
        @(negedge clk);
        resp_mul = 1'b0;
        resp_div = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called at a negedge in IDLE; returns at the negedge inside the ISSUE cycle.
  task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_valid = 1'b1;
    check1("req_ready_idle", req_ready, 1'b1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic release_result();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check1("res_valid_after_ack", res_valid, 1'b0);
  endtask

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       multi;
    logic [7:0] data;
    logic       zero;
    logic       err;
  } vec_t;

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{3'd0, 8'h1F, 8'h01, 1'b0, 8'h20, 1'b0, 1'b0};
    vecs[1]  = '{3'd0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2]  = '{3'd1, 8'h10, 8'h11, 1'b0, 8'hFF, 1'b0, 1'b0};
    vecs[3]  = '{3'd2, 8'hF0, 8'h0F, 1'b0, 8'hFF, 1'b0, 1'b0};
    vecs[4]  = '{3'd3, 8'hF0, 8'h0F, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[5]  = '{3'd4, 8'hA5, 8'h0F, 1'b0, 8'hAA, 1'b0, 1'b0};
    vecs[6]  = '{3'd7, 8'h00, 8'h33, 1'b0, 8'hFF, 1'b0, 1'b0};
    vecs[7]  = '{3'd7, 8'hFF, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[8]  = '{3'd5, 8'h0C, 8'h0B, 1'b1, 8'h84, 1'b0, 1'b0};
    vecs[9]  = '{3'd5, 8'h10, 8'h10, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[10] = '{3'd6, 8'h10, 8'h02, 1'b1, 8'h08, 1'b0, 1'b0};
    vecs[11] = '{3'd6, 8'h10, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b1};

    // Reset state.
    #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check1("rst_req_ready", req_ready, 1'b0);
    check8("rst_unit_sel", 8'(unit_sel), 8'h00);
    check8("rst_op_a", op_a, 8'h00);
    check8("rst_op_b", op_b, 8'h00);
    check8("rst_unit_en", unit_en, 8'h00);
    check1("rst_unit_start", unit_start, 1'b0);
    check1("rst_res_valid", res_valid, 1'b0);
    check8("rst_res_data", res_data, 8'h00);
    check1("rst_res_zero", res_zero, 1'b0);
    check1("rst_res_err", res_err, 1'b0);
    check1("rst_busy", busy, 1'b0);
    rst = 1'b0;
    #1 check1("req_ready_after_rst", req_ready, 1'b1);
    @(negedge clk);

    // Table-driven ops; single-cycle ops must show res_valid in the cycle after ISSUE.
    auto_done = 1'b1;
    for (int i = 0; i < 12; i++) begin
      send(vecs[i].op, vecs[i].a, vecs[i].b);
      check8("issue_unit_sel", 8'(unit_sel), 8'(vecs[i].op));
      check8("issue_unit_en", unit_en, 8'b1 << vecs[i].op);
      check1("issue_unit_start", unit_start, vecs[i].multi);
      check1("issue_res_valid", res_valid, 1'b0);
      if (!vecs[i].multi) begin
        @(negedge clk);
      end else begin
        for (int n = 0; n < 20 && !res_valid; n++) @(negedge clk);
      end
      check1("done_res_valid", res_valid, 1'b1);
      check8("done_res_data", res_data, vecs[i].data);
      check1("done_res_zero", res_zero, vecs[i].zero);
      check1("done_res_err", res_err, vecs[i].err);
      check8("done_unit_en", unit_en, 8'h00);
      check1("done_req_ready", req_ready, 1'b0);
      release_result();
    end
    auto_done = 1'b0;

    // XOR to zero: result held while the consumer stalls; new requests are refused.
    send(3'd4, 8'h5A, 8'h5A);
    @(negedge clk);
    req_op    = 3'd0;
    req_a     = 8'h01;
    req_b     = 8'h01;
    req_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check1("hold_res_valid", res_valid, 1'b1);
      check8("hold_res_data", res_data, 8'h00);
      check1("hold_res_zero", res_zero, 1'b1);
      check1("hold_req_ready", req_ready, 1'b0);
      @(negedge clk);
    end
    check8("hold_unit_sel", 8'(unit_sel), 8'd4);
    req_valid = 1'b0;
    release_result();
    check1("hold_req_ready_exit", req_ready, 1'b1);

    // Done strobes while idle are ignored.
    man_mul = 1'b1;
    man_div = 1'b1;
    @(negedge clk);
    man_mul = 1'b0;
    man_div = 1'b0;
    check1("idle_done_busy", busy, 1'b0);
    check1("idle_done_res_valid", res_valid, 1'b0);

    // MUL 0C*0B: one start, enable held through WAIT, stray div_done ignored.
    send(3'd5, 8'h0C, 8'h0B);
    check1("mul_start", unit_start, 1'b1);
    check8("mul_issue_en", unit_en, 8'h20);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      man_div = 1'b0;
      check8("mul_wait_en", unit_en, 8'h20);
      check1("mul_wait_start", unit_start, 1'b0);
      check1("mul_wait_res_valid", res_valid, 1'b0);
      man_div = (c == 2);
      man_mul = (c == 5);
    end
    @(negedge clk);
    man_mul = 1'b0;
    man_div = 1'b0;
    check1("mul_res_valid", res_valid, 1'b1);
    check8("mul_res_data", res_data, 8'h84);
    check1("mul_res_err", res_err, 1'b0);
    release_result();

`ifdef ALU_DISPATCH_TIMEOUT_EN
    // DIV with no done: error result after TO WAIT cycles.
    send(3'd6, 8'h10, 8'h02);
    for (int c = 1; c <= TO; c++) begin
      @(negedge clk);
      check1("to_wait_res_valid", res_valid, 1'b0);
    end
    @(negedge clk);
    check1("to_res_valid", res_valid, 1'b1);
    check8("to_res_data", res_data, 8'hFF);
    check1("to_res_err", res_err, 1'b1);
    check1("to_res_zero", res_zero, 1'b0);
    release_result();

    // Done on the timeout cycle wins.
    send(3'd6, 8'h10, 8'h02);
    for (int c = 1; c <= TO; c++) begin
      @(negedge clk);
      man_div = (c == TO);
    end
    @(negedge clk);
    man_div = 1'b0;
    check1("to_done_res_valid", res_valid, 1'b1);
    check8("to_done_res_data", res_data, 8'h08);
    check1("to_done_res_err", res_err, 1'b0);
    release_result();
`else
    // Without the timeout, WAIT holds until the done arrives.
    send(3'd6, 8'h10, 8'h02);
    repeat (30) @(negedge clk);
    check1("nto_busy", busy, 1'b1);
    check1("nto_res_valid", res_valid, 1'b0);
    man_div = 1'b1;
    @(negedge clk);
    man_div = 1'b0;
    check1("nto_res_valid_done", res_valid, 1'b1);
    check8("nto_res_data", res_data, 8'h08);
    check1("nto_res_err", res_err, 1'b0);
    release_result();
`endif

    // Reset pulsed mid-WAIT of a MUL, checked before any clock edge.
    send(3'd5, 8'h03, 8'h05);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check1("arst_req_ready", req_ready, 1'b0);
    check1("arst_busy", busy, 1'b0);
    check8("arst_unit_en", unit_en, 8'h00);
    check1("arst_unit_start", unit_start, 1'b0);
    check8("arst_unit_sel", 8'(unit_sel), 8'h00);
    check8("arst_op_a", op_a, 8'h00);
    check8("arst_res_data", res_data, 8'h00);
    check1("arst_res_valid", res_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    man_mul = 1'b1;
    @(negedge clk);
    man_mul = 1'b0;
    check1("arst_stale_done_res_valid", res_valid, 1'b0);
    send(3'd2, 8'h30, 8'h05);
    check8("post_rst_unit_sel", 8'(unit_sel), 8'd2);
    check1("post_rst_start", unit_start, 1'b0);
    @(negedge clk);
    check1("post_rst_res_valid", res_valid, 1'b1);
    check8("post_rst_res_data", res_data, 8'h35);
    release_result();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
